uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
Schedules one shared UART serial transmitter among NREQ byte requesters on sys_clk. Contains a runtime-programmable 16x-oversample tick generator, a round-robin arbiter with burst locking, and the start/data/stop framing state machine. Sits between on-chip message sources (PUF response, status, debug) and the board TX pin, replacing per-source transmitters.

Parameters:
NREQ, 4, number of requesters (2..8)
CW, 16, divider counter width
DIV_RST, 26, divider reload value after reset (tick every DIV_RST+1 sys_clk cycles)

Ports:
sys_clk  input  1  system clock; all logic on rising edge
sys_rst_l  input  1  asynchronous, active-low reset
div_val  input  CW  new divider value
div_load  input  1  one-cycle strobe: request divider update
req  input  NREQ  per-requester byte-valid, level
last  input  NREQ  per-requester end-of-burst flag, qualified by req
data  input  8*NREQ  per-requester byte; requester i on bits [8i+7:8i]
ack  output  NREQ  one-cycle pulse: byte of requester i consumed
gnt  output  NREQ  one-hot current owner, 0 when idle
txd  output  1  serial line, idle high
busy  output  1  high from grant until release

Behaviour:
- Reset: ack=0, gnt=0, txd=1, busy=0, state IDLE, RR pointer=0, divider=DIV_RST, tick counter=0, no pending divider load.
- Tick generator: counter increments each sys_clk; when counter==divider, counter->0 and tick=1 for one cycle. Free-running in all states.
- Divider update: div_load in IDLE -> divider=div_val and counter=0 next cycle. div_load while busy -> value latched as pending, applied on the cycle the FSM re-enters IDLE; a later div_load overwrites the pending value. div_val=0 is legal (tick every cycle).
- Arbitration (IDLE only): search req starting at pointer, wrapping modulo NREQ; first set bit i wins. Next cycle: gnt[i]=1, ack[i]=1 (one cycle), data and last[i] captured into shift register, busy=1, state START, txd=0, bit-tick counter=0.
- FSM states: IDLE, START, DATA, STOP. Each bit lasts 16 ticks. START -> DATA after 16 ticks; DATA shifts LSB first, 8 bits, 16 ticks each; STOP drives txd=1 for 16 ticks.
- End of STOP: if captured last=0 and req[i] high -> burst continues: ack[i] pulses, new byte captured, state START, gnt held, no arbitration. Otherwise -> gnt=0, busy=0, pointer=(i+1) mod NREQ, state IDLE. Minimum idle gap between bursts: 1 sys_clk cycle.
- Captured last=0 but req[i] low at end of STOP: grant released (no bus starvation by a stalled source).
- req deassertion mid-byte does not abort; the captured byte completes.
- Requesters must not change data[i]/last[i] while req[i] is high and ack[i] is low.
- Simultaneous div_load and arbitration win in IDLE: both take effect; the byte's first bit uses the new divider.
- Async reset mid-frame: txd returns high immediately, all state to reset values, pending divider discarded.

Optional Feature:
UART_TX_PARITY_EN: when defined, a PARITY state (16 ticks, even parity over the 8 data bits) is inserted between DATA and STOP; frame is 11 bits. When undefined, frame is 10 bits (8N1) and no parity logic exists.

Test Plan:
- Reset, DIV_RST=26: txd=1, gnt=0; tick period measured as 27 sys_clk cycles.
- req[2]=1, data=0xA5, last=1: next cycle gnt=4'b0100, ack[2] 1-cycle pulse; txd shows 0,1,0,1,0,0,1,0,1,1, each 16*27 cycles; then gnt=0, busy=0.
- req=4'b1111, all last=1, pointer 0: grant order 0,1,2,3,0; each burst is one byte.
- req[1] burst of 3 bytes (last on 3rd) with req[3] pending: three back-to-back frames for 1 without an idle bit, then 3 granted.
- div_load with div_val=3 mid-frame: current frame keeps 27-cycle ticks; next frame uses 4-cycle ticks.
- UART_TX_PARITY_EN, byte 0x07: parity bit=1, stop follows; async reset asserted mid-DATA -> txd=1 within same cycle, gnt=0.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one 16x-oversampled UART transmitter among NREQ byte sources.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_sched #(
  parameter int NREQ    = 4,
  parameter int CW      = 16,
  parameter int DIV_RST = 26
) (
  input  logic                sys_clk,
  input  logic                sys_rst_l,
  input  logic [CW-1:0]       div_val,
  input  logic                div_load,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     last,
  input  logic [8*NREQ-1:0]   data,
  output logic [NREQ-1:0]     ack,
  output logic [NREQ-1:0]     gnt,
  output logic                txd,
  output logic                busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t          state_q, state_nx;
  logic [CW-1:0]   div_q, cnt_q, pend_q;
  logic            pend_v;
  logic            tick, bit_done;
  logic [IW-1:0]   ptr_q, own_q, win_idx, cap_idx;
  logic            win_v;
  logic [NREQ-1:0] win_oh, gnt_q, ack_q;
  logic [7:0]      sh_q, cap_byte;
  logic [3:0]      bcnt_q;
  logic [2:0]      dcnt_q;
  logic            last_q;
  logic            grant_go, cont_go, release_go;
`ifdef UART_TX_PARITY_EN
  logic            par_q;
`endif

  assign tick     = (cnt_q == div_q);
  assign bit_done = tick && (bcnt_q == 4'd15);
  assign win_oh   = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
  assign cap_idx  = grant_go ? win_idx : own_q;
  assign cap_byte = data[{cap_idx, 3'b000} +: 8];
  assign ack      = ack_q;
  assign gnt      = gnt_q;
  assign busy     = (state_q != S_IDLE);

  // Search starts at the round-robin pointer and wraps modulo NREQ.
  always_comb begin
    logic [3:0] j;
    j       = '0;
    win_v   = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = 4'(ptr_q) + 4'(k);
      if (j >= 4'(NREQ)) j = j - 4'(NREQ);
      if (!win_v && req[j[IW-1:0]]) begin
        win_v   = 1'b1;
        win_idx = j[IW-1:0];
      end
    end
  end

  always_comb begin
    state_nx   = state_q;
    grant_go   = 1'b0;
    cont_go    = 1'b0;
    release_go = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_v) begin
          state_nx = S_START;
          grant_go = 1'b1;
        end
      end
      S_START: if (bit_done) state_nx = S_DATA;
      S_DATA: begin
        if (bit_done && dcnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_nx = S_PARITY;
`else
          state_nx = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_done) state_nx = S_STOP;
`endif
      S_STOP: begin
        if (bit_done) begin
          // A stalled source (req low before its last byte) loses the line.
          if (!last_q && req[own_q]) begin
            state_nx = S_START;
            cont_go  = 1'b1;
          end else begin
            state_nx   = S_IDLE;
            release_go = 1'b1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    case (state_q)
      S_START:  txd = 1'b0;
      S_DATA:   txd = sh_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd = par_q;
`endif
      default:  txd = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) state_q <= S_IDLE;
    else            state_q <= state_nx;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      ptr_q  <= '0;
      own_q  <= '0;
      gnt_q  <= '0;
      ack_q  <= '0;
      sh_q   <= '0;
      bcnt_q <= '0;
      dcnt_q <= '0;
      last_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
      if (grant_go || cont_go) begin
        if (grant_go) begin
          own_q <= win_idx;
          gnt_q <= win_oh;
          ack_q <= win_oh;
        end else begin
          ack_q <= gnt_q;
        end
        sh_q   <= cap_byte;
        last_q <= last[cap_idx];
        bcnt_q <= '0;
        dcnt_q <= '0;
`ifdef UART_TX_PARITY_EN
        par_q  <= ^cap_byte;
`endif
      end else if (release_go) begin
        gnt_q  <= '0;
        ptr_q  <= (own_q == IW'(NREQ-1)) ? '0 : own_q + 1'b1;
        bcnt_q <= '0;
      end else if (tick && state_q != S_IDLE) begin
        bcnt_q <= bcnt_q + 1'b1;
        if (state_q == S_DATA && bcnt_q == 4'd15) begin
          sh_q   <= sh_q >> 1;
          dcnt_q <= dcnt_q + 1'b1;
        end
      end
    end
  end

  // Divider changes while a frame is on the line wait until the line goes idle.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      div_q  <= CW'(DIV_RST);
      cnt_q  <= '0;
      pend_q <= '0;
      pend_v <= 1'b0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
      if (state_q == S_IDLE && div_load) begin
        div_q <= div_val;
        cnt_q <= '0;
      end else if (release_go) begin
        if (div_load) begin
          div_q <= div_val;
          cnt_q <= '0;
        end else if (pend_v) begin
          div_q <= pend_q;
          cnt_q <= '0;
        end
        pend_v <= 1'b0;
      end else if (div_load) begin
        pend_q <= div_val;
        pend_v <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: expected frames are queued at stimulus time and
// checked by an independent serial-line receiver.
module tb_uart_tx_sched;
  localparam int NREQ    = 4;
  localparam int CW      = 16;
  localparam int DIV_RST = 26;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic                sys_clk;
  logic                sys_rst_l;
  logic [CW-1:0]       div_val;
  logic                div_load;
  logic [NREQ-1:0]     req, last;
  logic [8*NREQ-1:0]   data;
  logic [NREQ-1:0]     ack, gnt;
  logic                txd, busy;

  // exp entry: [27]=burst continuation, [26:11]=sys_clk cycles per tick, [10:8]=owner, [7:0]=byte
  logic [27:0] exp_q[$];
  logic [8:0]  stim_q[NREQ][$];
  int          exp_ack[NREQ];
  int          act_ack[NREQ];
  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          cyc = 0;
  logic        mon_en = 1'b0;
  logic        mon_busy = 1'b0;

  uart_tx_sched #(.NREQ(NREQ), .CW(CW), .DIV_RST(DIV_RST)) dut (
    .sys_clk(sys_clk), .sys_rst_l(sys_rst_l), .div_val(div_val), .div_load(div_load),
    .req(req), .last(last), .data(data), .ack(ack), .gnt(gnt), .txd(txd), .busy(busy)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vec_cnt++;
    if (act !== expv) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    vec_cnt++;
    err_cnt++;
    $display("FAIL %s: timeout got no event expected event (cycle %0d)", name, cyc);
  endtask

  task automatic push_stim(input int i, input logic [7:0] b, input logic l);
    stim_q[i].push_back({l, b});
    exp_ack[i]++;
  endtask

  task automatic push_exp(input int i, input logic [7:0] b, input int d, input logic cont);
    exp_q.push_back({cont, 16'(d), 3'(i), b});
  endtask

  function automatic bit stim_pending();
    for (int i = 0; i < NREQ; i++) if (stim_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0 || mon_busy || stim_pending()) && t < 30000) begin
      @(negedge sys_clk);
      t++;
    end
    if (t >= 30000) timeout_fail(name);
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic wait_gnt(input int i, input string name);
    int t = 0;
    while (gnt[i] !== 1'b1 && t < 20000) begin
      @(negedge sys_clk);
      t++;
    end
    if (t >= 20000) timeout_fail(name);
  endtask

  // driver: presents the head of each requester's stimulus queue until acked
  initial begin
    req  = '0;
    last = '0;
    data = '0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_l) begin
        for (int i = 0; i < NREQ; i++) stim_q[i].delete();
        req = '0;
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          if (req[i] && ack[i]) void'(stim_q[i].pop_front());
          if (stim_q[i].size() > 0) begin
            req[i]          = 1'b1;
            data[8*i +: 8]  = stim_q[i][0][7:0];
            last[i]         = stim_q[i][0][8];
          end else begin
            req[i] = 1'b0;
          end
        end
      end
    end
  end

  // ack monitor: one-cycle pulses matching the current owner
  initial begin
    logic [NREQ-1:0] prev_ack;
    prev_ack = '0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_l && ack != '0) begin
        for (int i = 0; i < NREQ; i++) if (ack[i]) act_ack[i]++;
        chk("ack_vs_gnt", 32'(ack), 32'(gnt));
        chk("ack_width", 32'(prev_ack), 32'd0);
      end
      prev_ack = ack;
    end
  end

  // scoreboard: receive each frame off txd and compare with the queue head
  initial begin
    logic            prev, pv, tim_ok;
    logic [27:0]     e;
    logic [NB-1:0]   bits;
    logic [NREQ-1:0] oh;
    int              d, n_first, last_fall, gap;
    prev      = 1'b1;
    last_fall = 0;
    forever begin
      @(negedge sys_clk);
      if (mon_en && sys_rst_l && prev === 1'b1 && txd === 1'b0) begin
        mon_busy = 1'b1;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'(exp_q.size()), 32'd1);
        end else begin
          e  = exp_q.pop_front();
          d  = int'(e[26:11]);
          oh = NREQ'(1) << e[10:8];
          chk("gnt_at_start", 32'(gnt), 32'(oh));
          if (e[27]) begin
            gap = cyc - last_fall - (NB-1)*16*d;
            chk("burst_no_idle", 32'(gap >= 15*d+1 && gap <= 16*d), 32'd1);
          end
          last_fall = cyc;
          bits    = '0;
          n_first = 0;
          tim_ok  = 1'b1;
          pv      = txd;
          for (int n = 1; n <= (NB-1)*16*d + 7*d; n++) begin
            @(negedge sys_clk);
            if (txd !== pv) begin
              if (n_first == 0) begin
                n_first = n;
                if (!((n % (16*d)) == 0 || (n % (16*d)) > 15*d)) tim_ok = 1'b0;
              end else if (((n - n_first) % (16*d)) != 0) begin
                tim_ok = 1'b0;
              end
              pv = txd;
            end
            if ((n % (16*d)) == 7*d) bits[n/(16*d)] = txd;
          end
          chk("start_bit", 32'(bits[0]), 32'd0);
          chk("data_byte", 32'(bits[8:1]), 32'(e[7:0]));
`ifdef UART_TX_PARITY_EN
          chk("parity_bit", 32'(bits[9]), 32'(^e[7:0]));
`endif
          chk("stop_bit", 32'(bits[NB-1]), 32'd1);
          chk("bit_timing", 32'(tim_ok), 32'd1);
        end
        mon_busy = 1'b0;
      end
      prev = txd;
    end
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      exp_ack[i] = 0;
      act_ack[i] = 0;
    end
    sys_rst_l = 1'b0;
    div_val   = '0;
    div_load  = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    sys_rst_l = 1'b1;
    mon_en    = 1'b1;
    @(negedge sys_clk);

    // all four request single-byte bursts: grant order 0,1,2,3,0
    push_exp(0, 8'h11, 27, 1'b0);
    push_exp(1, 8'h22, 27, 1'b0);
    push_exp(2, 8'h33, 27, 1'b0);
    push_exp(3, 8'h44, 27, 1'b0);
    push_exp(0, 8'h55, 27, 1'b0);
    push_stim(0, 8'h11, 1'b1);
    push_stim(0, 8'h55, 1'b1);
    push_stim(1, 8'h22, 1'b1);
    push_stim(2, 8'h33, 1'b1);
    push_stim(3, 8'h44, 1'b1);
    wait_idle("rr_order");

    // single 0xA5 on requester 2
    push_exp(2, 8'hA5, 27, 1'b0);
    push_stim(2, 8'hA5, 1'b1);
    wait_gnt(2, "a5_gnt");
    chk("a5_busy", 32'(busy), 32'd1);
    wait_idle("a5_frame");
    chk("a5_gnt_released", 32'(gnt), 32'd0);
    chk("a5_busy_released", 32'(busy), 32'd0);

    // divider change mid-frame applies only to the following frame
    push_exp(0, 8'h3C, 27, 1'b0);
    push_exp(0, 8'hC3, 4, 1'b0);
    push_stim(0, 8'h3C, 1'b1);
    push_stim(0, 8'hC3, 1'b1);
    wait_gnt(0, "div_gnt");
    repeat (100) @(negedge sys_clk);
    div_val  = 16'd3;
    div_load = 1'b1;
    @(negedge sys_clk);
    div_load = 1'b0;
    wait_idle("div_change");

    // three-byte burst on requester 1 while 3 waits
    push_exp(1, 8'h01, 4, 1'b0);
    push_exp(1, 8'h80, 4, 1'b1);
    push_exp(1, 8'hF0, 4, 1'b1);
    push_exp(3, 8'h96, 4, 1'b0);
    push_stim(1, 8'h01, 1'b0);
    push_stim(1, 8'h80, 1'b0);
    push_stim(1, 8'hF0, 1'b1);
    wait_gnt(1, "burst_gnt");
    push_stim(3, 8'h96, 1'b1);
    wait_idle("burst");

    // divider 0 loaded while idle: tick every cycle
    div_val  = 16'd0;
    div_load = 1'b1;
    @(negedge sys_clk);
    div_load = 1'b0;
    push_exp(2, 8'h07, 1, 1'b0);
    push_stim(2, 8'h07, 1'b1);
    wait_idle("div_zero");

    // async reset in the middle of the data bits, with a divider update pending
    mon_en = 1'b0;
    push_stim(0, 8'h3C, 1'b1);
    wait_gnt(0, "rst_gnt_wait");
    repeat (36) @(negedge sys_clk);
    div_val  = 16'd5;
    div_load = 1'b1;
    @(negedge sys_clk);
    div_load = 1'b0;
    repeat (3) @(negedge sys_clk);
    @(posedge sys_clk);
    #2;
    chk("pre_rst_txd", 32'(txd), 32'd0);
    sys_rst_l = 1'b0;
    #1;
    chk("midrst_txd", 32'(txd), 32'd1);
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst_l = 1'b1;
    @(negedge sys_clk);
    mon_en = 1'b1;
    chk("post_rst_txd", 32'(txd), 32'd1);
    chk("post_rst_gnt", 32'(gnt), 32'd0);

    // divider back at reset value, pending update discarded
    push_exp(3, 8'h5A, 27, 1'b0);
    push_stim(3, 8'h5A, 1'b1);
    wait_idle("post_rst_frame");

    for (int i = 0; i < NREQ; i++) chk($sformatf("ack_count_%0d", i), 32'(act_ack[i]), 32'(exp_ack[i]));
    chk("exp_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
